bitty_if_prefetch: RTL

- Instruction-fetch prefetch unit between the bitty_riscv core fetch stage and the combinational instruction ROM (inst_rom).
- Runs ahead of the core. It drives sequential word addresses to the ROM and stores each {pc, instruction} pair in a small FIFO.
- The FIFO head is presented to the core through a valid/ready handshake.
- A redirect input (branch, jump or trap) flushes all buffered entries and restarts fetch at a new PC.

---
 rtl/bitty_if_prefetch_pkg.sv | 11 +
 rtl/bitty_if_prefetch_fifo.sv | 48 ++++
 rtl/bitty_if_prefetch.sv | 63 ++++++
 3 files changed

// File: rtl/bitty_if_prefetch_pkg.sv
// bitty_if_prefetch_pkg: shared constants and state encoding for the fetch prefetcher
package bitty_if_prefetch_pkg;
  localparam logic RstEnable = 1'b0;
  localparam logic RstDisable = 1'b1;
  localparam int InstAddrBus = 32;
  localparam int InstBus = 32;
  localparam logic [InstAddrBus-1:0] ResetPC = 32'h0000_0000;
  localparam logic [InstBus-1:0] NopInst = 32'h0000_0013;
  localparam int PrefetchDepth = 4;
  typedef enum logic {PF_BOOT = 1'b0, PF_RUN = 1'b1} pf_state_e;
endpackage

// File: rtl/bitty_if_prefetch_fifo.sv
// bitty_if_prefetch_fifo: synchronous FIFO with flush, async active-low reset
module bitty_if_prefetch_fifo
  import bitty_if_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data = r_mem[r_rd_ptr];
  assign w_push = i_push & ~o_full & ~i_clear;
  assign w_pop = i_pop & ~o_empty & ~i_clear;
  // pointers and occupancy; clear beats push and pop
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // storage is plain RAM; stale contents are masked by the count
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_data;
endmodule

// File: rtl/bitty_if_prefetch.sv
// bitty_if_prefetch: runs ahead of the core fetching sequential ROM words into a small FIFO
module bitty_if_prefetch
  import bitty_if_prefetch_pkg::*;
#(
  parameter logic [InstAddrBus-1:0] RESET_PC = ResetPC,
  parameter int                     DEPTH = PrefetchDepth,
  parameter logic [InstBus-1:0]     NOP_INST = NopInst
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce_o,
  output logic [InstAddrBus-1:0] rom_addr_o,
  input  logic [InstBus-1:0]     rom_data_i,
  input  logic                   redirect_i,
  input  logic [InstAddrBus-1:0] redirect_pc_i,
  output logic                   inst_valid_o,
  output logic [InstBus-1:0]     inst_o,
  output logic [InstAddrBus-1:0] inst_pc_o,
  input  logic                   inst_ready_i
);
  localparam logic [InstAddrBus-1:0] PcMask = 32'hFFFF_FFFC;
  pf_state_e r_state, w_state_nxt;
  logic [InstAddrBus-1:0] r_fetch_pc;
  logic w_push, w_pop, w_full, w_empty;
  logic [InstAddrBus+InstBus-1:0] w_head;
  logic [$clog2(DEPTH):0] w_count;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable) r_state <= PF_BOOT;
    else r_state <= w_state_nxt;
  // BOOT lasts one cycle so the ROM stays idle while reset releases
  always_comb w_state_nxt = (r_state == PF_BOOT) ? PF_RUN : r_state;
  // push never looks at a pop so ready has no path to the ROM enable
  always_comb begin
    w_push = (r_state == PF_RUN) & ~redirect_i & ~w_full;
    w_pop = inst_valid_o & inst_ready_i;
  end
  // fetch address: redirect wins, otherwise advance on every issued fetch
  always_ff @(posedge clk or negedge rst)
    if (rst == RstEnable) r_fetch_pc <= RESET_PC & PcMask;
    else if (redirect_i) r_fetch_pc <= redirect_pc_i & PcMask;
    else if (w_push) r_fetch_pc <= r_fetch_pc + 32'd4;
  bitty_if_prefetch_fifo #(
    .WIDTH(InstAddrBus + InstBus),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_clear(redirect_i),
    .i_data ({r_fetch_pc, rom_data_i}),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );
  assign rom_ce_o = w_push;
  assign rom_addr_o = r_fetch_pc;
  assign inst_valid_o = (w_count != '0) & ~redirect_i;
  assign inst_o = w_empty ? NOP_INST : w_head[InstBus-1:0];
  assign inst_pc_o = w_empty ? '0 : w_head[InstAddrBus+InstBus-1:InstBus];
endmodule
